// File: rtl/l2_pkg.sv
// Shared definitions for the L2-norm datapath.
//   L2_ACC_W        : width of the sum-of-squares accumulator output (f)
//   l2_sqrt_state_t : state encoding of the square-root stage
package l2_pkg;

    localparam int unsigned L2_ACC_W = 20;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } l2_sqrt_state_t;

endpackage

// File: rtl/l2_sqrt_stage.sv
// Final stage of the L2-norm datapath: the integer square root of the
// accumulated sum of squares. It uses a restoring digit-by-digit method and
// produces one root bit per clock. Results leave through a valid/ready handshake.
// Ports:
//   clk        clock; all logic runs on posedge
//   reset      synchronous active-low reset
//   sq_in      sum of squares (IN_W bits)
//   valid_in   sq_in valid; there is no backpressure toward the source
//   in_ready   high only while idle
//   root       root, floor or rounded (IN_W/2 bits)
//   rem        floor remainder sq_in - floor_root^2 (IN_W/2+1 bits)
//   out_valid  root/rem valid
//   out_ready  downstream accepts root/rem
//   drop_err   sticky; valid_in arrived while in_ready was low
module l2_sqrt_stage
    import l2_pkg::*;
#(
    parameter int unsigned IN_W  = L2_ACC_W,
    parameter bit          ROUND = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [IN_W-1:0]   sq_in,
    input  logic              valid_in,
    output logic              in_ready,
    output logic [IN_W/2-1:0] root,
    output logic [IN_W/2:0]   rem,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              drop_err
);

    localparam int unsigned ROOT_W = IN_W / 2;
    localparam int unsigned R_W    = ROOT_W + 2;
    localparam int unsigned ITER_W = (ROOT_W > 1) ? $clog2(ROOT_W) : 1;

    if ((IN_W % 2) != 0) begin : g_odd_width
        $error("l2_sqrt_stage: IN_W must be even");
    end

    l2_sqrt_state_t      state_q;
    logic [IN_W-1:0]     op_q;
    logic [R_W-1:0]      r_q;
    logic [ROOT_W-1:0]   q_q;
    logic [ITER_W-1:0]   iter_q;
    logic [ROOT_W-1:0]   root_q;
    logic [ROOT_W:0]     rem_q;
    logic                out_valid_q;
    logic                in_ready_q;
    logic                drop_err_q;

    logic [R_W-1:0]      r_shift;
    logic [R_W-1:0]      trial;
    logic [R_W-1:0]      step_r_d;
    logic [ROOT_W-1:0]   step_q_d;
    logic [ROOT_W-1:0]   root_d;

    // One restoring step. The operand register shifts left, so the next digit
    // pair is always its top two bits. The root is then rounded if enabled.
    always_comb begin
        r_shift  = {r_q[ROOT_W-1:0], op_q[IN_W-1 -: 2]};
        trial    = {q_q, 2'b01};
        step_r_d = r_shift;
        step_q_d = {q_q[ROOT_W-2:0], 1'b0};
        if (r_shift >= trial) begin
            step_r_d = r_shift - trial;
            step_q_d = {q_q[ROOT_W-2:0], 1'b1};
        end
        root_d = step_q_d;
        // Round up when rem > q (x exceeds q^2+q); an all-ones q saturates
        if (ROUND && (step_r_d > R_W'(step_q_d)) && !(&step_q_d)) begin
            root_d = step_q_d + ROOT_W'(1);
        end
    end

    // FSM and datapath registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            r_q         <= '0;
            q_q         <= '0;
            iter_q      <= '0;
            root_q      <= '0;
            rem_q       <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            drop_err_q  <= 1'b0;
        end else begin
            if (valid_in && !in_ready_q) begin
                drop_err_q <= 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (valid_in) begin
                        op_q       <= sq_in;
                        r_q        <= '0;
                        q_q        <= '0;
                        iter_q     <= ITER_W'(ROOT_W - 1);
                        in_ready_q <= 1'b0;
                        state_q    <= S_CALC;
                    end
                end
                S_CALC: begin
                    op_q   <= op_q << 2;
                    r_q    <= step_r_d;
                    q_q    <= step_q_d;
                    iter_q <= iter_q - ITER_W'(1);
                    if (iter_q == '0) begin
                        root_q      <= root_d;
                        rem_q       <= step_r_d[ROOT_W:0];
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end
                end
                S_DONE: begin
                    // Returning to idle takes a full edge, so there is no back-to-back accept
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign root      = root_q;
    assign rem       = rem_q;
    assign out_valid = out_valid_q;
    assign drop_err  = drop_err_q;

endmodule

// File: tb/tb_l2_sqrt_stage.sv
// Bench for l2_sqrt_stage. It runs a floor instance and a rounding instance side by side.
// A search-based integer sqrt model pushes the expected results into per-instance queues.
module tb_l2_sqrt_stage;

    localparam int unsigned IN_W   = 20;
    localparam int unsigned ROOT_W = IN_W / 2;

    typedef struct packed {
        logic [ROOT_W-1:0] root;
        logic [ROOT_W:0]   rem;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset;
    logic [IN_W-1:0]   sq_in;
    logic              valid_in;
    logic              out_ready;
    logic              ir0, ir1, ov0, ov1, de0, de1;
    logic [ROOT_W-1:0] root0, root1;
    logic [ROOT_W:0]   rem0, rem1;

    exp_t q0[$];
    exp_t q1[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    l2_sqrt_stage #(.IN_W(IN_W), .ROUND(1'b0)) u_floor (
        .clk(clk), .reset(reset), .sq_in(sq_in), .valid_in(valid_in),
        .in_ready(ir0), .root(root0), .rem(rem0), .out_valid(ov0),
        .out_ready(out_ready), .drop_err(de0)
    );

    l2_sqrt_stage #(.IN_W(IN_W), .ROUND(1'b1)) u_round (
        .clk(clk), .reset(reset), .sq_in(sq_in), .valid_in(valid_in),
        .in_ready(ir1), .root(root1), .rem(rem1), .out_valid(ov1),
        .out_ready(out_ready), .drop_err(de1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model: floor root by search, rounding by nearest-integer comparison
    task automatic push_expected(input int unsigned x);
        int unsigned q;
        int unsigned r;
        exp_t e;
        q = 0;
        while ((q + 1) * (q + 1) <= x) q++;
        r = x - q * q;
        e.root = ROOT_W'(q);
        e.rem  = (ROOT_W+1)'(r);
        q0.push_back(e);
        if ((r > q) && (q < (1 << ROOT_W) - 1)) e.root = ROOT_W'(q + 1);
        q1.push_back(e);
    endtask

    task automatic start_op(input int unsigned x);
        chk("in_ready_before_accept", 32'(ir0), 32'd1);
        sq_in    = IN_W'(x);
        valid_in = 1'b1;
        push_expected(x);
        tick();
        valid_in = 1'b0;
        chk("in_ready_after_accept", 32'(ir0), 32'd0);
    endtask

    task automatic wait_result(input string tag);
        int lat;
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (ov0) begin
                lat = n;
                break;
            end
        end
        chk({tag, "_latency"}, 32'(lat), 32'd10);
        chk({tag, "_round_valid"}, 32'(ov1), 32'd1);
    endtask

    task automatic check_out(input string tag, output exp_t e0, output exp_t e1);
        e0 = '0;
        e1 = '0;
        chk({tag, "_sb_depth"}, 32'(q0.size() + q1.size()), 32'd2);
        if (q0.size() > 0) e0 = q0.pop_front();
        if (q1.size() > 0) e1 = q1.pop_front();
        chk({tag, "_root_floor"}, 32'(root0), 32'(e0.root));
        chk({tag, "_rem_floor"},  32'(rem0),  32'(e0.rem));
        chk({tag, "_root_round"}, 32'(root1), 32'(e1.root));
        chk({tag, "_rem_round"},  32'(rem1),  32'(e1.rem));
    endtask

    task automatic run_op(input string tag, input int unsigned x);
        exp_t e0, e1;
        start_op(x);
        wait_result(tag);
        check_out(tag, e0, e1);
        tick();
        chk({tag, "_valid_drop"}, 32'(ov0), 32'd0);
        chk({tag, "_idle_ready"}, 32'(ir0), 32'd1);
    endtask

    initial begin : stim
        exp_t e0, e1;
        int unsigned acc;
        int unsigned a_vals[2];

        reset     = 1'b0;
        sq_in     = '0;
        valid_in  = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        reset = 1'b1;
        tick();
        tick();

        // Reset held for two edges while idle
        reset = 1'b0;
        tick();
        tick();
        chk("rst_in_ready",  32'(ir0),   32'd1);
        chk("rst_out_valid", 32'(ov0),   32'd0);
        chk("rst_root",      32'(root0), 32'd0);
        chk("rst_rem",       32'(rem0),  32'd0);
        chk("rst_drop_err",  32'(de0),   32'd0);
        chk("rst_round_rdy", 32'(ir1),   32'd1);
        reset = 1'b1;
        tick();

        // Zero operand still takes the full latency
        run_op("zero", 0);

        run_op("x144", 144);
        run_op("x150", 150);
        run_op("x156", 156);
        run_op("x157", 157);
        run_op("xmax", 20'hFFFFF);
        // Boundary constants written directly for the saturating/max case
        chk("max_root_sat", 32'(root1), 32'd1023);
        chk("max_rem",      32'(rem1),  32'd2046);

        // Backpressure hold, plus a dropped input during DONE
        out_ready = 1'b0;
        start_op(150);
        wait_result("hold");
        check_out("hold", e0, e1);
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid",    32'(ov0),   32'd1);
            chk("hold_root",     32'(root0), 32'(e0.root));
            chk("hold_rem",      32'(rem0),  32'(e0.rem));
            chk("hold_in_ready", 32'(ir0),   32'd0);
            if (i == 2) valid_in = 1'b1;
            tick();
            valid_in = 1'b0;
        end
        chk("drop_err_set", 32'(de0), 32'd1);
        chk("drop_err_set_round", 32'(de1), 32'd1);
        out_ready = 1'b1;
        tick();
        chk("hold_release_valid", 32'(ov0), 32'd0);
        chk("hold_release_ready", 32'(ir0), 32'd1);
        chk("drop_err_sticky",    32'(de0), 32'd1);
        tick();
        chk("drop_err_sticky2",   32'(de0), 32'd1);

        // Reset in the middle of a calculation discards it
        start_op(150);
        tick();
        tick();
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        q0.delete();
        q1.delete();
        chk("midrst_valid",    32'(ov0), 32'd0);
        chk("midrst_ready",    32'(ir0), 32'd1);
        chk("midrst_drop_err", 32'(de0), 32'd0);
        run_op("x400", 400);

        // Accumulated operand from an upstream sum of squares: 3^2 + 4^2
        a_vals[0] = 3;
        a_vals[1] = 4;
        acc = 0;
        foreach (a_vals[i]) acc += a_vals[i] * a_vals[i];
        run_op("acc25", acc);
        chk("acc25_root", 32'(root0), 32'd5);

        // A few random operands against the model
        for (int k = 0; k < 6; k++) begin
            run_op("rand", $urandom_range(0, 20'hFFFFF));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
